fp_norm_round_pipe: RTL and testbench

Parametrised, pipelined normalise/round/pack stage for the FPU adder-subtractor datapath. Takes the raw sign, biased exponent and extended (carry + hidden + fraction + G/R/S) mantissa from the add/sub core and produces an IEEE-754 packed result with RISC-V exception flags. Unlike the existing combinational normaliser, it is width-generic (FP16/FP32/FP64), has three registered stages with a valid/ready handshake and flush, and handles subnormals, overflow saturation and flag generation.

---
 rtl/fpu_pkg.sv | 29 ++
 rtl/fp_norm_round_pipe_if.sv | 29 ++
 rtl/fp_norm_round_pipe_lzc.sv | 18 +
 rtl/fp_norm_round_pipe.sv | 171 +++++++++++++++++
 tb/tb_fp_norm_round_pipe.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, exception flag positions and
// exponent-range helpers used by the normalise/round/pack pipeline.
package fpu_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  // Bit positions inside the 5-bit {NV, DZ, OF, UF, NX} flag vector.
  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  function automatic int exp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // All-ones exponent field: the inf/NaN encoding, first overflowing value.
  function automatic int exp_max(input int ew);
    return (1 << ew) - 1;
  endfunction

endpackage

// File: rtl/fp_norm_round_pipe_if.sv
// Producer/consumer bundle for the normalise/round/pack pipeline: input op,
// output result and the pipeline-wide flush.
interface fp_norm_round_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sign;
  logic [EXP_W-1:0]       in_exp;
  logic [MAN_W+4:0]       in_mant;
  logic                   in_eq;
  logic [2:0]             in_rm;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   out_res;
  logic [4:0]             out_flags;

  modport master (
    output flush, in_valid, in_sign, in_exp, in_mant, in_eq, in_rm, out_ready,
    input  in_ready, out_valid, out_res, out_flags
  );

  modport slave (
    input  flush, in_valid, in_sign, in_exp, in_mant, in_eq, in_rm, out_ready,
    output in_ready, out_valid, out_res, out_flags
  );
endinterface

// File: rtl/fp_norm_round_pipe_lzc.sv
// Combinational leading-zero counter; cnt_o = W when the input is all zero.
module fp_lzc #(
  parameter  int W  = 27,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in_i,
  output logic [CW-1:0] cnt_o,
  output logic          zero_o
);
  // Scanning upward lets the highest set bit win the last assignment.
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++)
      if (in_i[i]) cnt_o = CW'(W - 1 - i);
  end

  assign zero_o = ~|in_i;
endmodule

// File: rtl/fp_norm_round_pipe.sv
// Three-stage normalise -> round -> pack for the FPU add/sub datapath, with a
// stall-capable valid/ready pipeline and flush.
module fp_norm_round_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic                  clk,
  input logic                  rst,
  fp_norm_round_pipe_if.slave  bus
);
  localparam int MW = MAN_W + 5;
  localparam int NM = MW - 1;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(NM + 1);
  localparam int RW = EXP_W + MAN_W + 1;
  localparam logic signed [EW-1:0] ONE     = EW'(1);
  localparam logic signed [EW-1:0] EXP_INF = EW'(exp_max(EXP_W));

  // ---------------- pipeline control ----------------
  logic [3:1] vld_q, vld_d, ld;

  always_comb begin
    ld[3] = !vld_q[3] || bus.out_ready;
    ld[2] = !vld_q[2] || ld[3];
    ld[1] = !vld_q[1] || ld[2];
    vld_d = vld_q;
    if (bus.flush) begin
      vld_d = '0;
    end else begin
      if (ld[1]) vld_d[1] = bus.in_valid;
      if (ld[2]) vld_d[2] = vld_q[1];
      if (ld[3]) vld_d[3] = vld_q[2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  assign bus.in_ready = ld[1];

  // ---------------- S1: normalise ----------------
  logic [CW-1:0]          lz;
  logic                   mzero;
  logic signed [EW-1:0]   e_in, e_lz, s1_exp_d, s1_exp_q;
  logic [EW-1:0]          sub_sh;
  logic [NM-1:0]          s1_man_d, s1_man_q;
  logic                   s1_zero_d, s1_zero_q, s1_sign_q, s1_eq_q;
  rm_e                    s1_rm_d, s1_rm_q;

  fp_lzc #(.W(NM)) u_lzc (
    .in_i   (bus.in_mant[NM-1:0]),
    .cnt_o  (lz),
    .zero_o (mzero)
  );

  // Subnormal case shifts only far enough to land on exponent 1, then stores 0.
  always_comb begin
    e_in     = signed'({2'b00, bus.in_exp});
    e_lz     = signed'(EW'(lz));
    sub_sh   = e_in - ONE;
    s1_man_d = bus.in_mant[NM-1:0];
    s1_exp_d = '0;
    if (bus.in_mant[MW-1]) begin
      s1_man_d = {bus.in_mant[MW-1:2], |bus.in_mant[1:0]};
      s1_exp_d = e_in + ONE;
    end else if (e_in > e_lz) begin
      s1_man_d = bus.in_mant[NM-1:0] << lz;
      s1_exp_d = e_in - e_lz;
    end else if (e_in != '0) begin
      s1_man_d = bus.in_mant[NM-1:0] << sub_sh;
    end
    s1_zero_d = bus.in_eq || (mzero && !bus.in_mant[MW-1]);
    s1_rm_d   = (bus.in_rm > 3'd4) ? RM_RNE : rm_e'(bus.in_rm);
  end

  always_ff @(posedge clk) begin
    if (ld[1]) begin
      s1_sign_q <= bus.in_sign;
      s1_exp_q  <= s1_exp_d;
      s1_man_q  <= s1_man_d;
      s1_zero_q <= s1_zero_d;
      s1_eq_q   <= bus.in_eq;
      s1_rm_q   <= s1_rm_d;
    end
  end

  // ---------------- S2: round ----------------
  logic                   lsb, g, r, st, inc;
  logic [MAN_W+1:0]       sum;
  logic signed [EW-1:0]   s2_exp_d, s2_exp_q;
  logic [MAN_W-1:0]       s2_frac_d, s2_frac_q;
  logic                   s2_sign_q, s2_nx_q, s2_zero_q, s2_eq_q;
  rm_e                    s2_rm_q;

  always_comb begin
    {lsb, g, r, st} = s1_man_q[3:0];
    case (s1_rm_q)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s1_sign_q && (g || r || st);
      RM_RUP:  inc = !s1_sign_q && (g || r || st);
      RM_RMM:  inc = g;
      default: inc = g && (r || st || lsb);
    endcase
    sum       = {1'b0, s1_man_q[NM-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    s2_exp_d  = s1_exp_q;
    s2_frac_d = sum[MAN_W-1:0];
    if (sum[MAN_W+1]) begin
      s2_exp_d  = s1_exp_q + ONE;
      s2_frac_d = '0;
    end else if (s1_exp_q == '0 && sum[MAN_W]) begin
      s2_exp_d  = ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (ld[2]) begin
      s2_sign_q <= s1_sign_q;
      s2_exp_q  <= s2_exp_d;
      s2_frac_q <= s2_frac_d;
      s2_nx_q   <= g || r || st;
      s2_zero_q <= s1_zero_q;
      s2_eq_q   <= s1_eq_q;
      s2_rm_q   <= s1_rm_q;
    end
  end

  // ---------------- S3: pack / exceptions ----------------
  logic [RW-1:0] res_d, res_q;
  logic [4:0]    flags_d, flags_q;
  logic          to_inf;

  always_comb begin
    case (s2_rm_q)
      RM_RTZ:  to_inf = 1'b0;
      RM_RDN:  to_inf = s2_sign_q;
      RM_RUP:  to_inf = !s2_sign_q;
      default: to_inf = 1'b1;
    endcase
    res_d           = {s2_sign_q, s2_exp_q[EXP_W-1:0], s2_frac_q};
    flags_d         = '0;
    flags_d[FLG_NX] = s2_nx_q;
    flags_d[FLG_UF] = s2_nx_q && (s2_exp_q == '0);
    if (s2_zero_q) begin
      res_d       = '0;
      res_d[RW-1] = s2_eq_q ? (s2_rm_q == RM_RDN) : s2_sign_q;
      flags_d     = '0;
    end else if (s2_exp_q >= EXP_INF) begin
      res_d = to_inf ? {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                     : {s2_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      flags_d         = '0;
      flags_d[FLG_OF] = 1'b1;
      flags_d[FLG_NX] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ld[3]) begin
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  // Result registers are not reset, so idle outputs are forced to zero.
  assign bus.out_valid = vld_q[3];
  assign bus.out_res   = vld_q[3] ? res_q   : '0;
  assign bus.out_flags = vld_q[3] ? flags_q : '0;
endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Directed bench for fp_norm_round_pipe at FP32 and FP16 widths.
module tb_fp_norm_round_pipe;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_norm_round_pipe_if #(.EXP_W(8), .MAN_W(23)) b32 ();
  fp_norm_round_pipe_if #(.EXP_W(5), .MAN_W(10)) b16 ();

  fp_norm_round_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  fp_norm_round_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          f16;
    bit          s;
    logic [7:0]  e;
    logic [27:0] m;
    bit          eq;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [4:0]  fl;
  } vec_t;

  function automatic logic ovld(input bit f16);
    return f16 ? b16.out_valid : b32.out_valid;
  endfunction
  function automatic logic irdy(input bit f16);
    return f16 ? b16.in_ready : b32.in_ready;
  endfunction
  function automatic logic [31:0] ores(input bit f16);
    return f16 ? {16'h0, b16.out_res} : b32.out_res;
  endfunction
  function automatic logic [4:0] oflg(input bit f16);
    return f16 ? b16.out_flags : b32.out_flags;
  endfunction

  task automatic set_ctl(input bit f16, input bit fl, input bit ordy);
    if (f16) begin b16.flush = fl; b16.out_ready = ordy; end
    else     begin b32.flush = fl; b32.out_ready = ordy; end
  endtask

  task automatic drive(input bit f16, input bit v, input bit s, input logic [7:0] e,
                       input logic [27:0] m, input bit eq, input logic [2:0] rm);
    if (f16) begin
      b16.in_valid = v; b16.in_sign = s; b16.in_exp = e[4:0];
      b16.in_mant = m[14:0]; b16.in_eq = eq; b16.in_rm = rm;
    end else begin
      b32.in_valid = v; b32.in_sign = s; b32.in_exp = e;
      b32.in_mant = m; b32.in_eq = eq; b32.in_rm = rm;
    end
  endtask

  // Issues one op into an idle pipe and waits (bounded) for its result.
  task automatic run_op(input vec_t v, output logic [31:0] res, output logic [4:0] fl,
                        output int lat);
    @(negedge clk);
    drive(v.f16, 1'b1, v.s, v.e, v.m, v.eq, v.rm);
    @(posedge clk);
    #1 drive(v.f16, 1'b0, 1'b0, 8'd0, 28'd0, 1'b0, 3'd0);
    lat = 0; res = '0; fl = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ovld(v.f16)) begin
        lat = k; res = ores(v.f16); fl = oflg(v.f16);
        break;
      end
    end
  endtask

  task automatic run_table(input string tag, input vec_t tv[$]);
    logic [31:0] res; logic [4:0] fl; int lat;
    foreach (tv[i]) begin
      run_op(tv[i], res, fl, lat);
      vectors++;
      if (lat != 3) begin
        miscompares++;
        $display("FAIL %s[%0d] latency got %0d want 3", tag, i, lat);
      end
      vectors++;
      if (res !== tv[i].res) begin
        miscompares++;
        $display("FAIL %s[%0d] res got %h want %h", tag, i, res, tv[i].res);
      end
      vectors++;
      if (fl !== tv[i].fl) begin
        miscompares++;
        $display("FAIL %s[%0d] flags got %b want %b", tag, i, fl, tv[i].fl);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (ovld(1'b0) !== 1'b0 || ovld(1'b1) !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid got %b/%b want 0/0", ovld(1'b0), ovld(1'b1));
    end
    vectors++;
    if (irdy(1'b0) !== 1'b1 || irdy(1'b1) !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready got %b/%b want 1/1", irdy(1'b0), irdy(1'b1));
    end
    vectors++;
    if (ores(1'b0) !== 32'h0 || oflg(1'b0) !== 5'h0) begin
      miscompares++; $display("FAIL reset_out_res got %h/%b want 0/0", ores(1'b0), oflg(1'b0));
    end
  endtask

  task automatic test_normalise();
    vec_t tv[$];
    tv.push_back('{0, 0, 8'd127, 28'h4000000, 0, 3'd0, 32'h3F800000, 5'h00});
    tv.push_back('{0, 0, 8'd127, 28'h8000000, 0, 3'd0, 32'h40000000, 5'h00});
    tv.push_back('{0, 0, 8'd127, 28'h0000008, 0, 3'd0, 32'h34000000, 5'h00});
    tv.push_back('{0, 0, 8'd1,   28'h2000000, 0, 3'd0, 32'h00400000, 5'h00});
    tv.push_back('{0, 1, 8'd127, 28'h0000000, 0, 3'd0, 32'h80000000, 5'h00});
    tv.push_back('{1, 0, 8'd15,  28'h0002000, 0, 3'd0, 32'h00003C00, 5'h00});
    run_table("norm", tv);
  endtask

  task automatic test_rounding();
    vec_t tv[$];
    tv.push_back('{0, 0, 8'd127, 28'h4000004, 0, 3'd0, 32'h3F800000, 5'h01});
    tv.push_back('{0, 0, 8'd127, 28'h400000C, 0, 3'd0, 32'h3F800002, 5'h01});
    tv.push_back('{0, 0, 8'd127, 28'h400000C, 0, 3'd1, 32'h3F800001, 5'h01});
    tv.push_back('{0, 0, 8'd127, 28'h400000C, 0, 3'd5, 32'h3F800002, 5'h01});
    tv.push_back('{0, 0, 8'd127, 28'h4000004, 0, 3'd3, 32'h3F800001, 5'h01});
    tv.push_back('{0, 0, 8'd127, 28'h4000004, 0, 3'd2, 32'h3F800000, 5'h01});
    tv.push_back('{0, 0, 8'd127, 28'h4000004, 0, 3'd4, 32'h3F800001, 5'h01});
    tv.push_back('{0, 0, 8'd127, 28'h7FFFFFC, 0, 3'd0, 32'h40000000, 5'h01});
    tv.push_back('{0, 0, 8'd1,   28'h3FFFFFC, 0, 3'd0, 32'h00800000, 5'h01});
    tv.push_back('{0, 0, 8'd1,   28'h2000004, 0, 3'd0, 32'h00400000, 5'h03});
    run_table("round", tv);
  endtask

  task automatic test_overflow();
    vec_t tv[$];
    tv.push_back('{0, 0, 8'd254, 28'h8000000, 0, 3'd0, 32'h7F800000, 5'h05});
    tv.push_back('{0, 0, 8'd254, 28'h8000000, 0, 3'd1, 32'h7F7FFFFF, 5'h05});
    tv.push_back('{0, 1, 8'd254, 28'h8000000, 0, 3'd3, 32'hFF7FFFFF, 5'h05});
    tv.push_back('{0, 1, 8'd254, 28'h8000000, 0, 3'd2, 32'hFF800000, 5'h05});
    tv.push_back('{0, 0, 8'd127, 28'h4000000, 1, 3'd2, 32'h80000000, 5'h00});
    tv.push_back('{0, 1, 8'd127, 28'h4000000, 1, 3'd0, 32'h00000000, 5'h00});
    tv.push_back('{1, 0, 8'd30,  28'h0004000, 0, 3'd0, 32'h00007C00, 5'h05});
    run_table("ovf", tv);
  endtask

  task automatic test_back_to_back();
    logic [31:0] got[$];
    logic [31:0] hold_val = '0;
    int sent = 0, cyc = 0;
    bit dropped = 0, held = 0, stall_seen = 0, unstable = 0;
    while (got.size() < 6 && cyc < 40) begin
      @(negedge clk);
      b32.out_ready = !(cyc >= 4 && cyc < 8);
      drive(1'b0, sent < 6, 1'b0, 8'(127 + sent), 28'h4000000, 1'b0, 3'd0);
      #1;
      if (b32.out_valid && !b32.out_ready) begin
        if (held && b32.out_res !== hold_val) unstable = 1;
        held = 1; stall_seen = 1; hold_val = b32.out_res;
      end else held = 0;
      if (b32.out_valid && b32.out_ready) got.push_back(b32.out_res);
      if (b32.in_valid && !b32.in_ready) dropped = 1;
      if (b32.in_valid && b32.in_ready) sent++;
      cyc++;
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0, 28'd0, 1'b0, 3'd0);
    b32.out_ready = 1'b1;
    vectors++;
    if (got.size() != 6) begin
      miscompares++; $display("FAIL b2b_count got %0d want 6", got.size());
    end
    foreach (got[i]) begin
      vectors++;
      if (got[i] !== 32'h3F800000 + (32'(i) << 23)) begin
        miscompares++;
        $display("FAIL b2b_order[%0d] got %h want %h", i, got[i], 32'h3F800000 + (32'(i) << 23));
      end
    end
    vectors++;
    if (!(dropped && stall_seen)) begin
      miscompares++; $display("FAIL b2b_backpressure in_ready_drop %0d stall %0d want 1 1", dropped, stall_seen);
    end
    vectors++;
    if (unstable) begin
      miscompares++; $display("FAIL b2b_hold out_res changed while stalled, want stable");
    end
  endtask

  task automatic test_flush(input bit f16);
    logic [27:0] m1 = f16 ? 28'h0002000 : 28'h4000000;
    logic [7:0]  e1 = f16 ? 8'd15 : 8'd127;
    vec_t one;
    logic [31:0] res; logic [4:0] fl; int lat, seen;
    one = '{f16, 0, e1, m1, 0, 3'd0, f16 ? 32'h3C00 : 32'h3F800000, 5'h00};
    @(negedge clk);
    set_ctl(f16, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(f16, 1'b1, 1'b0, e1, m1, 1'b0, 3'd0);
      @(negedge clk);
    end
    drive(f16, 1'b0, 1'b0, 8'd0, 28'd0, 1'b0, 3'd0);
    #1;
    vectors++;
    if (ovld(f16) !== 1'b1 || irdy(f16) !== 1'b0) begin
      miscompares++; $display("FAIL flush%0d_full out_valid %b in_ready %b want 1 0", f16, ovld(f16), irdy(f16));
    end
    set_ctl(f16, 1'b1, 1'b0);
    @(posedge clk);
    #1 set_ctl(f16, 1'b0, 1'b1);
    seen = 0;
    repeat (6) begin @(negedge clk); if (ovld(f16)) seen++; end
    vectors++;
    if (seen != 0 || irdy(f16) !== 1'b1) begin
      miscompares++; $display("FAIL flush%0d_kill emitted %0d in_ready %b want 0 1", f16, seen, irdy(f16));
    end
    drive(f16, 1'b1, 1'b0, e1, m1, 1'b0, 3'd0);
    set_ctl(f16, 1'b1, 1'b1);
    @(posedge clk);
    #1 drive(f16, 1'b0, 1'b0, 8'd0, 28'd0, 1'b0, 3'd0);
    set_ctl(f16, 1'b0, 1'b1);
    seen = 0;
    repeat (6) begin @(negedge clk); if (ovld(f16)) seen++; end
    vectors++;
    if (seen != 0) begin
      miscompares++; $display("FAIL flush%0d_drop_input emitted %0d want 0", f16, seen);
    end
    run_op(one, res, fl, lat);
    vectors++;
    if (res !== one.res || lat != 3) begin
      miscompares++; $display("FAIL flush%0d_after res %h lat %0d want %h 3", f16, res, lat, one.res);
    end
  endtask

  task automatic test_reset_midstream();
    vec_t one;
    logic [31:0] res; logic [4:0] fl; int lat, seen;
    one = '{0, 0, 8'd127, 28'h4000000, 0, 3'd0, 32'h3F800000, 5'h00};
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'd127, 28'h4000000, 1'b0, 3'd0);
    drive(1'b1, 1'b1, 1'b0, 8'd15, 28'h0002000, 1'b0, 3'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 28'd0, 1'b0, 3'd0);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 28'd0, 1'b0, 3'd0);
    #1;
    vectors++;
    if (ovld(1'b0) !== 1'b0 || irdy(1'b0) !== 1'b1 || ores(1'b0) !== 32'h0) begin
      miscompares++;
      $display("FAIL rstmid_state out_valid %b in_ready %b res %h want 0 1 0", ovld(1'b0), irdy(1'b0), ores(1'b0));
    end
    seen = 0;
    repeat (6) begin @(negedge clk); if (ovld(1'b0) || ovld(1'b1)) seen++; end
    vectors++;
    if (seen != 0) begin
      miscompares++; $display("FAIL rstmid_discard emitted %0d want 0", seen);
    end
    run_op(one, res, fl, lat);
    vectors++;
    if (res !== 32'h3F800000 || lat != 3) begin
      miscompares++; $display("FAIL rstmid_after res %h lat %0d want 3f800000 3", res, lat);
    end
  endtask

  initial begin
    set_ctl(1'b0, 1'b0, 1'b1);
    set_ctl(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 28'd0, 1'b0, 3'd0);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 28'd0, 1'b0, 3'd0);
    test_reset();
    test_normalise();
    test_rounding();
    test_overflow();
    test_back_to_back();
    test_flush(1'b0);
    test_flush(1'b1);
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, vectors %0d", vectors);
    $fatal(1);
  end
endmodule
